// File: rtl/riscv_multi_ctrl.sv
// Multi-cycle control FSM for the RV32I multi-cycle core.
// Moore outputs from the current state plus combinational decode of the latched instruction.
module riscv_multi_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  output logic        pc_we_o,
  output logic        ir_we_o,
  output logic        mem_we_o,
  output logic        reg_we_o,
  output logic        adr_src_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  res_src_o,
  output logic [2:0]  imm_src_o,
  output logic [3:0]  alu_ctrl_o,
  output logic        error_o,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_ERROR    = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // I-type ops share the R-type table; only funct3 000 ignores the alt bit (addi has no subi).
  function automatic logic [3:0] alu_decode(input logic [2:0] funct3,
                                            input logic       alt,
                                            input logic       is_rtype);
    logic [3:0] code;
    code = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (alt && is_rtype) code = ALU_SUB;
        else                 code = ALU_ADD;
      end
      3'b001: code = ALU_SLL;
      3'b010: code = ALU_SLT;
      3'b011: code = ALU_SLTU;
      3'b100: code = ALU_XOR;
      3'b101: begin
        if (alt) code = ALU_SRA;
        else     code = ALU_SRL;
      end
      3'b110: code = ALU_OR;
      3'b111: code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  state_e      state_q;
  state_e      state_d;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        funct7b5_s;
  logic        unused_instr_s;

  logic        pc_we_s;
  logic        ir_we_s;
  logic        mem_we_s;
  logic        reg_we_s;
  logic        adr_src_s;
  logic [1:0]  alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [1:0]  res_src_s;
  logic [3:0]  alu_ctrl_s;
  logic        error_s;

  assign opcode_s       = instr_i[6:0];
  assign funct3_s       = instr_i[14:12];
  assign funct7b5_s     = instr_i[30];
  assign unused_instr_s = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_s)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_BRANCH: begin
            if (funct3_s == 3'b000 || funct3_s == 3'b001) state_d = S_BRANCH;
            else                                          state_d = S_ERROR;
          end
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        if (opcode_s == OP_STORE) state_d = S_MEMWRITE;
        else                      state_d = S_MEMREAD;
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  // Moore control outputs per state.
  always_comb begin
    pc_we_s     = 1'b0;
    ir_we_s     = 1'b0;
    mem_we_s    = 1'b0;
    reg_we_s    = 1'b0;
    adr_src_s   = 1'b0;
    alu_src_a_s = 2'b00;
    alu_src_b_s = 2'b00;
    res_src_s   = 2'b00;
    alu_ctrl_s  = ALU_ADD;
    error_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we_s     = 1'b1;
        pc_we_s     = 1'b1;
        alu_src_b_s = 2'b10;
        res_src_s   = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: adr_src_s = 1'b1;
      S_MEMWB: begin
        res_src_s = 2'b01;
        reg_we_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s = 1'b1;
        mem_we_s  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_ctrl_s  = alu_decode(funct3_s, funct7b5_s, 1'b1);
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_ctrl_s  = alu_decode(funct3_s, funct7b5_s, 1'b0);
      end
      S_ALUWB: reg_we_s = 1'b1;
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_we_s     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s = 2'b10;
        alu_ctrl_s  = ALU_SUB;
        // funct3[0] distinguishes bne from beq
        if (funct3_s[0]) pc_we_s = ~zero_i;
        else             pc_we_s = zero_i;
      end
      S_LUI: begin
        alu_src_a_s = 2'b11;
        alu_src_b_s = 2'b01;
      end
      S_ERROR: error_s = 1'b1;
      default: error_s = 1'b1;
    endcase
  end

  // Immediate format straight from the opcode, independent of state.
  always_comb begin
    imm_src_o = IMM_I;
    case (opcode_s)
      OP_LOAD, OP_ITYPE: imm_src_o = IMM_I;
      OP_STORE:          imm_src_o = IMM_S;
      OP_BRANCH:         imm_src_o = IMM_B;
      OP_JAL:            imm_src_o = IMM_J;
      OP_LUI:            imm_src_o = IMM_U;
      default:           imm_src_o = IMM_I;
    endcase
  end

  // Reset masks every write enable and the error flag in the reset cycle itself.
  always_comb begin
    alu_src_a_o = alu_src_a_s;
    alu_src_b_o = alu_src_b_s;
    res_src_o   = res_src_s;
    alu_ctrl_o  = alu_ctrl_s;
    adr_src_o   = adr_src_s;
    state_o     = state_q;
    if (rst_i) begin
      pc_we_o  = 1'b0;
      ir_we_o  = 1'b0;
      mem_we_o = 1'b0;
      reg_we_o = 1'b0;
      error_o  = 1'b0;
    end else begin
      pc_we_o  = pc_we_s;
      ir_we_o  = ir_we_s;
      mem_we_o = mem_we_s;
      reg_we_o = reg_we_s;
      error_o  = error_s;
    end
  end

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Self-checking bench for riscv_multi_ctrl: directed test-plan instructions, random
// instruction streams against an instruction-level reference model, resets and illegal opcodes.
`timescale 1ns/1ps
module tb_riscv_multi_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        pc_we, ir_we, mem_we, reg_we, adr_src, error;
  logic [1:0]  alu_src_a, alu_src_b, res_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl, state;

  int checks = 0;
  int errors = 0;
  int seq_q[$];

  riscv_multi_ctrl dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .zero_i(zero),
    .pc_we_o(pc_we), .ir_we_o(ir_we), .mem_we_o(mem_we), .reg_we_o(reg_we),
    .adr_src_o(adr_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .res_src_o(res_src), .imm_src_o(imm_src), .alu_ctrl_o(alu_ctrl),
    .error_o(error), .state_o(state)
  );

  always #5 clk = ~clk;

  // Expected state walk for one instruction, from the cycles-per-instruction table.
  task automatic build_seq(input logic [31:0] ins);
    seq_q.delete();
    case (ins[6:0])
      7'b0000011: seq_q = '{0, 1, 2, 3, 4};
      7'b0100011: seq_q = '{0, 1, 2, 5};
      7'b0110011: seq_q = '{0, 1, 6, 8};
      7'b0010011: seq_q = '{0, 1, 7, 8};
      7'b1101111: seq_q = '{0, 1, 9, 8};
      7'b0110111: seq_q = '{0, 1, 11, 8};
      7'b1100011: seq_q = (ins[14:13] == 2'b00) ? '{0, 1, 10} : '{0, 1, 15};
      default:    seq_q = '{0, 1, 15};
    endcase
  endtask

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 3'd1;
    if (op == 7'b1100011) return 3'd2;
    if (op == 7'b1101111) return 3'd3;
    if (op == 7'b0110111) return 3'd4;
    return 3'd0;
  endfunction

  // Mnemonic-level ALU operation for an R or I arithmetic instruction.
  function automatic logic [3:0] ref_alu(input logic [31:0] ins, input bit is_r);
    logic [3:0] tbl [8];
    logic [3:0] op;
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    op = tbl[ins[14:12]];
    if (ins[14:12] == 3'd0 && is_r && ins[30]) op = 4'd1;
    if (ins[14:12] == 3'd5 && ins[30]) op = 4'd9;
    return op;
  endfunction

  // Bundle {pc,ir,mem,reg,adr,a,b,res,alu,err} expected in a given state.
  function automatic logic [15:0] ref_ctrl(input int st, input logic [31:0] ins, input logic z);
    logic pc, ir, mw, rw, adr, err;
    logic [1:0] a, b, res;
    logic [3:0] alu;
    pc = 1'b0; ir = 1'b0; mw = 1'b0; rw = 1'b0; adr = 1'b0; err = 1'b0;
    a = 2'd0; b = 2'd0; res = 2'd0; alu = 4'd0;
    case (st)
      0:  begin pc = 1'b1; ir = 1'b1; b = 2'd2; res = 2'd2; end
      1:  begin a = 2'd1; b = 2'd1; end
      2:  begin a = 2'd2; b = 2'd1; end
      3:  adr = 1'b1;
      4:  begin res = 2'd1; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin a = 2'd2; alu = ref_alu(ins, 1'b1); end
      7:  begin a = 2'd2; b = 2'd1; alu = ref_alu(ins, 1'b0); end
      8:  rw = 1'b1;
      9:  begin a = 2'd1; b = 2'd2; pc = 1'b1; end
      10: begin a = 2'd2; alu = 4'd1; pc = ins[12] ? ~z : z; end
      11: begin a = 2'd3; b = 2'd1; end
      15: err = 1'b1;
      default: err = 1'b1;
    endcase
    return {pc, ir, mw, rw, adr, a, b, res, alu, err};
  endfunction

  // Runs one legal instruction from FETCH back to FETCH, checking every cycle.
  task automatic test_program(input logic [31:0] ins, input logic z);
    logic [15:0] got;
    logic [15:0] exp;
    instr = ins;
    zero  = z;
    build_seq(ins);
    foreach (seq_q[k]) begin
      @(negedge clk);
      got = {pc_we, ir_we, mem_we, reg_we, adr_src, alu_src_a, alu_src_b, res_src, alu_ctrl, error};
      exp = ref_ctrl(seq_q[k], ins, z);
      checks++;
      if (state !== 4'(seq_q[k])) begin
        errors++;
        $display("FAIL state instr=%h step=%0d got=%0d expected=%0d", ins, k, state, seq_q[k]);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ctrl instr=%h step=%0d got=%h expected=%h", ins, k, got, exp);
      end
      checks++;
      if (imm_src !== ref_imm(ins[6:0])) begin
        errors++;
        $display("FAIL imm_src instr=%h got=%0d expected=%0d", ins, imm_src, ref_imm(ins[6:0]));
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Holds reset for a few cycles; leaves the FSM in FETCH just after an edge.
  task automatic test_reset();
    rst   = 1'b1;
    instr = 32'h0020a223;
    zero  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({pc_we, ir_we, mem_we, reg_we, error} !== 5'b0) begin
        errors++;
        $display("FAIL reset_enables got=%b expected=00000", {pc_we, ir_we, mem_we, reg_we, error});
      end
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL reset_state got=%0d expected=0", state);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    test_program(32'hfffff0b7, 1'b0);
    test_program(32'hfffff0b7, 1'b1);
    test_program(32'h0040a103, 1'b0);
    test_program(32'h0020a223, 1'b0);
    test_program(32'h00208463, 1'b1);
    test_program(32'h00208463, 1'b0);
    test_program(32'h00209463, 1'b1);
    test_program(32'h00209463, 1'b0);
    test_program(32'h402081b3, 1'b0);
    test_program(32'h4010d093, 1'b0);
    test_program(32'h008000ef, 1'b0);
  endtask

  task automatic test_random(input int n);
    logic [6:0]  ops [7];
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111, 7'b1100011};
    for (int i = 0; i < n; i++) begin
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(0, 6)];
      if (ins[6:0] == 7'b1100011) ins[14:12] = 3'($urandom_range(0, 1));
      test_program(ins, 1'($urandom_range(0, 1)));
    end
  endtask

  // Reset asserted during the MEMWB write-back must suppress reg_we and restart at FETCH.
  task automatic test_reset_mid();
    instr = 32'h0040a103;
    zero  = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc_we, ir_we, mem_we, reg_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_enables state=%0d got=%b expected=0000", state, {pc_we, ir_we, mem_we, reg_we});
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_state got=%0d expected=0", state);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_program(32'h0020a223, 1'b0);
  endtask

  // Illegal encodings land in ERROR, stay there with enables low, and leave only via reset.
  task automatic test_illegal();
    logic [31:0] bad [4];
    bad = '{32'h0000007f, 32'h0020a063 | (32'($urandom_range(2, 7)) << 12), 32'h00000073, 32'h00000067};
    foreach (bad[j]) begin
      instr = bad[j];
      zero  = 1'b1;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      repeat (10) begin
        @(negedge clk);
        checks++;
        if (state !== 4'd15 || error !== 1'b1) begin
          errors++;
          $display("FAIL illegal_hold instr=%h got state=%0d error=%b expected state=15 error=1", bad[j], state, error);
        end
        checks++;
        if ({pc_we, ir_we, mem_we, reg_we} !== 4'b0) begin
          errors++;
          $display("FAIL illegal_enables instr=%h got=%b expected=0000", bad[j], {pc_we, ir_we, mem_we, reg_we});
        end
        checks++;
        if (imm_src !== ref_imm(bad[j][6:0])) begin
          errors++;
          $display("FAIL illegal_imm instr=%h got=%0d expected=%0d", bad[j], imm_src, ref_imm(bad[j][6:0]));
        end
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (error !== 1'b0) begin
        errors++;
        $display("FAIL illegal_rst_error got=%b expected=0", error);
      end
      @(negedge clk);
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL illegal_rst_state got=%0d expected=0", state);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      test_program(32'hfffff0b7, 1'b0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    instr = 32'h0;
    zero  = 1'b0;
    test_reset();
    test_directed();
    test_random(300);
    test_reset_mid();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_multi_ctrl.md
# riscv_multi_ctrl

Multi-cycle control FSM for the RV32I multi-cycle core: sequences a single shared memory, register file, ALU and PC/IR/data registers across several clock cycles per instruction. Sits beside the multi-cycle datapath, takes the latched instruction and the ALU zero flag, and drives every write enable and mux select as a Moore function of state plus combinational decode of `instr`. Supported instructions:
- lw, sw
- R-type ALU, I-type ALU
- beq, bne
- jal, lui

## Interface
- No parameters.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7[5] = bit 30).
- `zero`  in  1  ALU zero flag.
- `pc_we`  out  1  PC register write.
- `ir_we`  out  1  instruction/old-PC register write.
- `mem_we`  out  1  memory write.
- `reg_we`  out  1  register file write.
- `adr_src`  out  1  memory address: 0 = PC, 1 = result.
- `alu_src_a`  out  2  00 PC, 01 old PC, 10 rs1, 11 constant 0.
- `alu_src_b`  out  2  00 rs2, 01 immediate, 10 constant 4.
- `res_src`  out  2  00 ALU-out register, 01 memory-data register, 10 ALU result.
- `imm_src`  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_ctrl`  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- `error`  out  1  high in ERROR state.
- `state`  out  4  current state (debug).

## Operation
- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE
  - 6 EXECR, 7 EXECI, 8 ALUWB, 9 JAL, 10 BRANCH, 11 LUI, 15 ERROR
- Default in every state: all write enables 0, `alu_ctrl` ADD, selects 0.
- `imm_src` is always combinational from opcode:
  - 0000011/0010011 → I
  - 0100011 → S
  - 1100011 → B
  - 1101111 → J
  - 0110111 → U
  - anything else → I
- FETCH: `adr_src`=0, `ir_we`=1, a=00, b=10, ADD, `res_src`=10, `pc_we`=1 → DECODE.
- DECODE: a=01, b=01, ADD (target into ALU-out register). Next state by opcode:
  - lw/sw → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 0110111 → LUI
  - 1100011 with funct3 000/001 → BRANCH
  - else → ERROR
- MEMADR: a=10, b=01, ADD → MEMREAD (lw) / MEMWRITE (sw).
- MEMREAD: `res_src`=00, `adr_src`=1 → MEMWB.
- MEMWB: `res_src`=01, `reg_we`=1 → FETCH.
- MEMWRITE: `res_src`=00, `adr_src`=1, `mem_we`=1 → FETCH.
- EXECR: a=10, b=00, R-decode → ALUWB.
- EXECI: a=10, b=01, I-decode → ALUWB.
- ALUWB: `res_src`=00, `reg_we`=1 → FETCH.
- JAL: a=01, b=10, ADD, `res_src`=00, `pc_we`=1 → ALUWB (rd ← old PC + 4).
- BRANCH: a=10, b=00, SUB, `res_src`=00. `pc_we` = `zero` for beq, `!zero` for bne → FETCH.
- LUI: a=11, b=01, ADD → ALUWB.
- ERROR: all enables 0, `error`=1. Holds until `rst`.
- R-decode by funct3:
  - 000: SUB if funct7[5], else ADD
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101: SRA if funct7[5], else SRL
  - 110 OR, 111 AND
- I-decode: same as R-decode, except 000 is always ADD.

## Timing
- Cycles per instruction:
  - lw 5
  - sw, R, I, jal, lui 4
  - beq/bne 3
- Outputs are combinational from `state` and `instr`. No output is registered.
- While `rst`=1: `pc_we`, `ir_we`, `mem_we`, `reg_we` forced 0 and `error`=0. State is FETCH on the first edge after `rst` falls.
- Reset mid-instruction (any state, including ERROR) aborts the instruction. No write enable may be asserted in the reset cycle.
- `zero` is sampled only in BRANCH. `instr` must be stable from DECODE until the instruction returns to FETCH.

## Test plan
- Reset, IR = 0xfffff0b7 (lui x1,0xfffff):
  - state 0,1,11,8, repeating
  - in LUI: a=11, b=01, `imm_src`=100, `alu_ctrl`=0000
  - `reg_we`=1 only in ALUWB (4th cycle); `pc_we`=1 only in FETCH.
- lw x2,4(x1) (0x0040a103):
  - states 0,1,2,3,4
  - `adr_src`=1 in MEMREAD; `res_src`=01 with `reg_we`=1 in MEMWB.
- sw (0x0020a223):
  - states 0,1,2,5
  - `mem_we`=1 for exactly one cycle; `reg_we` never 1.
- beq:
  - with `zero`=1: `pc_we`=1 in BRANCH, `alu_ctrl`=0001
  - with `zero`=0: `pc_we`=0
  - bne gives the inverse; both take 3 cycles.
- sub x3,x1,x2 (0x402081b3): `alu_ctrl`=0001 in EXECR. srai (0x4010d093): 1001 in EXECI.
- Illegal opcode (0x0000007f):
  - DECODE → 15, `error`=1 held 10 cycles with all enables 0
  - `rst` pulse → state 0, `error`=0.
